// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stall controller for a five-stage MIPS pipeline.
// Tracks in-flight writers in EX, MEM and WB in a private scoreboard. It
// drives the EX ALU operand muxes and the ID branch comparator muxes,
// raises load-use and branch-in-ID stalls, and counts stall and flush events.
module pipe_hazard_unit #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned BR_IN_ID = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr,
    input  logic [REG_W-1:0] id_wrreg,
    input  logic             id_load,
    input  logic             id_branch,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a_ex,
    output logic [1:0]       fwd_b_ex,
    output logic [1:0]       fwd_a_id,
    output logic [1:0]       fwd_b_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             BR_EN   = (BR_IN_ID != 0);

    // EX slot: the full record, because EX forwarding needs its sources.
    logic             ex_valid_q, ex_valid_d;
    logic             ex_wr_q, ex_wr_d;
    logic [REG_W-1:0] ex_wrreg_q, ex_wrreg_d;
    logic             ex_load_q, ex_load_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    logic             ex_use_rs_q, ex_use_rs_d;
    logic             ex_use_rt_q, ex_use_rt_d;

    // MEM and WB slots: only the writer fields are ever consulted.
    logic             mem_valid_q;
    logic             mem_wr_q;
    logic [REG_W-1:0] mem_wrreg_q;
    logic             mem_load_q;
    logic             wb_valid_q;
    logic             wb_wr_q;
    logic [REG_W-1:0] wb_wrreg_q;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use, br_stall;
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic [1:0] id_sel_a, id_sel_b;

    // A record writes r when it is live, writes, targets r, and r is not $0.
    function automatic logic writes_reg(input logic             v,
                                        input logic             wr,
                                        input logic [REG_W-1:0] wreg,
                                        input logic [REG_W-1:0] r);
        return v & wr & (wreg == r) & (r != '0);
    endfunction

    // Forward select: a non-load MEM writer is the youngest usable value,
    // otherwise the WB value, otherwise the register file.
    function automatic logic [1:0] fwd_sel(input logic used,
                                           input logic mem_hit,
                                           input logic mem_is_load,
                                           input logic wb_hit);
        logic [1:0] sel;
        sel = 2'd0;
        if (used && mem_hit && !mem_is_load) begin
            sel = 2'd1;
        end else if (used && wb_hit) begin
            sel = 2'd2;
        end
        return sel;
    endfunction

    // Stall detection against the ID instruction's in-use sources.
    always_comb begin
        ex_hit_rs  = id_use_rs & writes_reg(ex_valid_q, ex_wr_q, ex_wrreg_q, id_rs);
        ex_hit_rt  = id_use_rt & writes_reg(ex_valid_q, ex_wr_q, ex_wrreg_q, id_rt);
        mem_hit_rs = id_use_rs & writes_reg(mem_valid_q, mem_wr_q, mem_wrreg_q, id_rs);
        mem_hit_rt = id_use_rt & writes_reg(mem_valid_q, mem_wr_q, mem_wrreg_q, id_rt);
        load_use   = ex_load_q & (ex_hit_rs | ex_hit_rt);
        br_stall   = BR_EN & id_branch &
                     (ex_hit_rs | ex_hit_rt | (mem_load_q & (mem_hit_rs | mem_hit_rt)));
        // A killed instruction never stalls.
        stall      = id_valid & ~flush & (load_use | br_stall);
    end

    // ALU operand forwarding from the EX slot's own sources.
    always_comb begin
        fwd_a_ex = fwd_sel(ex_use_rs_q,
                           writes_reg(mem_valid_q, mem_wr_q, mem_wrreg_q, ex_rs_q),
                           mem_load_q,
                           writes_reg(wb_valid_q, wb_wr_q, wb_wrreg_q, ex_rs_q));
        fwd_b_ex = fwd_sel(ex_use_rt_q,
                           writes_reg(mem_valid_q, mem_wr_q, mem_wrreg_q, ex_rt_q),
                           mem_load_q,
                           writes_reg(wb_valid_q, wb_wr_q, wb_wrreg_q, ex_rt_q));
    end

    // Branch comparator forwarding from the ID inputs, also while stalling.
    always_comb begin
        id_sel_a = fwd_sel(1'b1,
                           writes_reg(mem_valid_q, mem_wr_q, mem_wrreg_q, id_rs),
                           mem_load_q,
                           writes_reg(wb_valid_q, wb_wr_q, wb_wrreg_q, id_rs));
        id_sel_b = fwd_sel(1'b1,
                           writes_reg(mem_valid_q, mem_wr_q, mem_wrreg_q, id_rt),
                           mem_load_q,
                           writes_reg(wb_valid_q, wb_wr_q, wb_wrreg_q, id_rt));
        fwd_a_id = BR_EN ? id_sel_a : 2'd0;
        fwd_b_id = BR_EN ? id_sel_b : 2'd0;
    end

    // Next EX record: the ID instruction if it advances, else an all-zero bubble.
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_wr_d     = 1'b0;
        ex_wrreg_d  = '0;
        ex_load_d   = 1'b0;
        ex_rs_d     = '0;
        ex_rt_d     = '0;
        ex_use_rs_d = 1'b0;
        ex_use_rt_d = 1'b0;
        if (id_valid && !stall && !flush) begin
            ex_valid_d  = 1'b1;
            ex_wr_d     = id_wr;
            ex_wrreg_d  = id_wrreg;
            ex_load_d   = id_load;
            ex_rs_d     = id_rs;
            ex_rt_d     = id_rt;
            ex_use_rs_d = id_use_rs;
            ex_use_rt_d = id_use_rt;
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush && id_valid && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Scoreboard shift and counter update; reset discards all in-flight records.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_wrreg_q  <= '0;
            ex_load_q   <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_use_rs_q <= 1'b0;
            ex_use_rt_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wrreg_q <= '0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_wr_q     <= 1'b0;
            wb_wrreg_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_valid_q  <= mem_valid_q;
            wb_wr_q     <= mem_wr_q;
            wb_wrreg_q  <= mem_wrreg_q;
            mem_valid_q <= ex_valid_q;
            mem_wr_q    <= ex_wr_q;
            mem_wrreg_q <= ex_wrreg_q;
            mem_load_q  <= ex_load_q;
            ex_valid_q  <= ex_valid_d;
            ex_wr_q     <= ex_wr_d;
            ex_wrreg_q  <= ex_wrreg_d;
            ex_load_q   <= ex_load_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_use_rs_q <= ex_use_rs_d;
            ex_use_rt_q <= ex_use_rt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit. Two instances share one stimulus:
// u0 uses the default parameters, u1 has BR_IN_ID = 0 and CNT_W = 2.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_v = 0, i_urs = 0, i_urt = 0, i_wr = 0, i_ld = 0, i_br = 0, i_fl = 0;
    logic [4:0] i_rs = 0, i_rt = 0, i_wreg = 0;

    logic        s0, s1;
    logic [1:0]  fae0, fbe0, fai0, fbi0, fae1, fbe1, fai1, fbi1;
    logic [15:0] sc0, fc0;
    logic [1:0]  sc1, fc1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(i_v), .id_rs(i_rs), .id_rt(i_rt),
        .id_use_rs(i_urs), .id_use_rt(i_urt), .id_wr(i_wr), .id_wrreg(i_wreg),
        .id_load(i_ld), .id_branch(i_br), .flush(i_fl), .stall(s0),
        .fwd_a_ex(fae0), .fwd_b_ex(fbe0), .fwd_a_id(fai0), .fwd_b_id(fbi0),
        .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_hazard_unit #(.REG_W(5), .BR_IN_ID(0), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(i_v), .id_rs(i_rs), .id_rt(i_rt),
        .id_use_rs(i_urs), .id_use_rt(i_urt), .id_wr(i_wr), .id_wrreg(i_wreg),
        .id_load(i_ld), .id_branch(i_br), .flush(i_fl), .stall(s1),
        .fwd_a_ex(fae1), .fwd_b_ex(fbe1), .fwd_a_id(fai1), .fwd_b_id(fbi1),
        .stall_cnt(sc1), .flush_cnt(fc1));

    // Reference model: the instructions sitting in EX (0), MEM (1), WB (2).
    typedef struct {
        int v; int wr; int wreg; int ld; int rs; int rt; int urs; int urt;
    } rec_t;

    rec_t pipe [2][3];
    int   scnt [2];
    int   fcnt [2];
    int   brp  [2] = '{1, 0};
    int   cmax [2] = '{65535, 3};

    function automatic int writes(rec_t x, int r);
        return (x.v != 0 && x.wr != 0 && x.wreg == r && r != 0) ? 1 : 0;
    endfunction

    function automatic int fsel(int k, int r);
        if (writes(pipe[k][1], r) != 0 && pipe[k][1].ld == 0) return 1;
        if (writes(pipe[k][2], r) != 0) return 2;
        return 0;
    endfunction

    function automatic int reads(int k, int s, int r_is_rs);
        // does the ID instruction read a register written by slot s?
        if (r_is_rs != 0) return (i_urs && writes(pipe[k][s], int'(i_rs)) != 0) ? 1 : 0;
        return (i_urt && writes(pipe[k][s], int'(i_rt)) != 0) ? 1 : 0;
    endfunction

    function automatic int exp_stall(int k);
        int ex_dep, mem_dep, lu, bs;
        ex_dep  = reads(k, 0, 1) | reads(k, 0, 0);
        mem_dep = reads(k, 1, 1) | reads(k, 1, 0);
        lu = (pipe[k][0].ld != 0 && ex_dep != 0) ? 1 : 0;
        bs = (brp[k] != 0 && i_br && (ex_dep != 0 || (pipe[k][1].ld != 0 && mem_dep != 0))) ? 1 : 0;
        return (i_v && !i_fl && (lu != 0 || bs != 0)) ? 1 : 0;
    endfunction

    function automatic int exp_fae(int k);
        return (pipe[k][0].urs != 0) ? fsel(k, pipe[k][0].rs) : 0;
    endfunction
    function automatic int exp_fbe(int k);
        return (pipe[k][0].urt != 0) ? fsel(k, pipe[k][0].rt) : 0;
    endfunction
    function automatic int exp_fai(int k);
        return (brp[k] != 0) ? fsel(k, int'(i_rs)) : 0;
    endfunction
    function automatic int exp_fbi(int k);
        return (brp[k] != 0) ? fsel(k, int'(i_rt)) : 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) pipe[k][s] = '{default: 0};
            scnt[k] = 0;
            fcnt[k] = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances with the model.
    task automatic check_model();
        chk("stall_u0", int'(s0), exp_stall(0));
        chk("fwd_a_ex_u0", int'(fae0), exp_fae(0));
        chk("fwd_b_ex_u0", int'(fbe0), exp_fbe(0));
        chk("fwd_a_id_u0", int'(fai0), exp_fai(0));
        chk("fwd_b_id_u0", int'(fbi0), exp_fbi(0));
        chk("stall_cnt_u0", int'(sc0), scnt[0]);
        chk("flush_cnt_u0", int'(fc0), fcnt[0]);
        chk("stall_u1", int'(s1), exp_stall(1));
        chk("fwd_a_ex_u1", int'(fae1), exp_fae(1));
        chk("fwd_b_ex_u1", int'(fbe1), exp_fbe(1));
        chk("fwd_a_id_u1", int'(fai1), exp_fai(1));
        chk("fwd_b_id_u1", int'(fbi1), exp_fbi(1));
        chk("stall_cnt_u1", int'(sc1), scnt[1]);
        chk("flush_cnt_u1", int'(fc1), fcnt[1]);
    endtask

    // Apply one ID instruction, let it settle, and compare.
    task automatic drive(input int v, input int rs, input int rt, input int urs, input int urt,
                         input int wr, input int wreg, input int ld, input int br, input int fl);
        i_v = (v != 0); i_rs = 5'(rs); i_rt = 5'(rt); i_urs = (urs != 0); i_urt = (urt != 0);
        i_wr = (wr != 0); i_wreg = 5'(wreg); i_ld = (ld != 0); i_br = (br != 0); i_fl = (fl != 0);
        #1;
        check_model();
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock and move the model along with it.
    task automatic tick();
        int st;
        rec_t nr;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int s = 0; s < 3; s++) pipe[k][s] = '{default: 0};
                scnt[k] = 0;
                fcnt[k] = 0;
            end else begin
                st = exp_stall(k);
                if (st != 0 && scnt[k] < cmax[k]) scnt[k]++;
                if (i_fl && i_v && fcnt[k] < cmax[k]) fcnt[k]++;
                nr = '{default: 0};
                if (i_v && st == 0 && !i_fl)
                    nr = '{1, int'(i_wr), int'(i_wreg), int'(i_ld), int'(i_rs), int'(i_rt),
                           int'(i_urs), int'(i_urt)};
                pipe[k][2] = pipe[k][1];
                pipe[k][1] = pipe[k][0];
                pipe[k][0] = nr;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            nop();
            tick();
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        // reset state with a would-be-hazard on the inputs
        drive(1, 8, 8, 1, 1, 1, 9, 0, 1, 0);
        chk("reset_stall", int'(s0), 0);
        chk("reset_fwd_a_id", int'(fai0), 0);
        tick();
        rst_n = 1'b1;
        drain();

        // ALU chain: add $3; add $5,$3,$4; add $6,$3,$0
        drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0); tick();
        drive(1, 3, 4, 1, 1, 1, 5, 0, 0, 0);
        chk("alu_no_stall", int'(s0), 0);
        tick();
        drive(1, 3, 0, 1, 1, 1, 6, 0, 0, 0);
        chk("alu_fwd_mem", int'(fae0), 1);
        tick();
        nop();
        chk("alu_fwd_wb", int'(fae0), 2);
        tick();
        drain();

        // Load-use: lw $1; add $2,$1,$1
        drive(1, 29, 0, 1, 0, 1, 1, 1, 0, 0); tick();
        drive(1, 1, 1, 1, 1, 1, 2, 0, 0, 0);
        chk("lu_stall", int'(s0), 1);
        tick();
        drive(1, 1, 1, 1, 1, 1, 2, 0, 0, 0);
        chk("lu_stall_over", int'(s0), 0);
        tick();
        nop();
        chk("lu_fwd_a", int'(fae0), 2);
        chk("lu_fwd_b", int'(fbe0), 2);
        chk("lu_stall_cnt", int'(sc0), 1);
        tick();
        drain();

        // Branch after load: lw $4; beq $4,$0 held until issued
        drive(1, 29, 0, 1, 0, 1, 4, 1, 0, 0); tick();
        drive(1, 4, 0, 1, 1, 0, 0, 0, 1, 0);
        chk("brld_stall1", int'(s0), 1);
        chk("brld_u1_fwd_id", int'(fai1), 0);
        tick();
        drive(1, 4, 0, 1, 1, 0, 0, 0, 1, 0);
        chk("brld_stall2", int'(s0), 1);
        chk("brld_u1_no_stall", int'(s1), 0);
        tick();
        drive(1, 4, 0, 1, 1, 0, 0, 0, 1, 0);
        chk("brld_stall_done", int'(s0), 0);
        chk("brld_fwd_id", int'(fai0), 2);
        tick();
        drain();

        // lw $4; nop; beq $4 -- BR_IN_ID = 0 never stalls
        drive(1, 29, 0, 1, 0, 1, 4, 1, 0, 0); tick();
        nop(); tick();
        drive(1, 4, 0, 1, 1, 0, 0, 0, 1, 0);
        chk("br_mem_ld_stall", int'(s0), 1);
        chk("br_off_stall", int'(s1), 0);
        chk("br_off_fwd_id", int'(fai1), 0);
        tick();
        drain();

        // Branch after ALU: add $7; beq $7,$0
        drive(1, 1, 2, 1, 1, 1, 7, 0, 0, 0); tick();
        drive(1, 7, 0, 1, 1, 0, 0, 0, 1, 0);
        chk("bralu_stall", int'(s0), 1);
        tick();
        drive(1, 7, 0, 1, 1, 0, 0, 0, 1, 0);
        chk("bralu_stall_done", int'(s0), 0);
        chk("bralu_fwd_id", int'(fai0), 1);
        tick();
        drain();

        // Register 0: load into $0 then read $0
        drive(1, 1, 2, 1, 1, 1, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 1, 9, 0, 1, 0);
        chk("r0_no_stall", int'(s0), 0);
        tick();
        nop();
        chk("r0_fwd_a_ex", int'(fae0), 0);
        chk("r0_fwd_b_ex", int'(fbe0), 0);
        tick();
        drain();

        // Flush: load-use condition killed; flushed load leaves a bubble
        chk("flush_cnt_before", int'(fc0), 0);
        drive(1, 29, 0, 1, 0, 1, 1, 1, 0, 0); tick();
        drive(1, 1, 1, 1, 1, 1, 2, 0, 0, 1);
        chk("flush_no_stall", int'(s0), 0);
        tick();
        drive(1, 29, 0, 1, 0, 1, 10, 1, 0, 1); tick();
        drive(1, 10, 10, 1, 1, 1, 11, 0, 0, 0);
        chk("flush_bubble", int'(s0), 0);
        chk("flush_cnt", int'(fc0), 2);
        tick();
        drain();

        // Saturation on u1: five load-use stalls
        for (int n = 0; n < 5; n++) begin
            drive(1, 29, 0, 1, 0, 1, 1, 1, 0, 0); tick();
            drive(1, 1, 0, 1, 0, 1, 2, 0, 0, 0);
            chk("sat_stall", int'(s1), 1);
            tick();
            drive(1, 1, 0, 1, 0, 1, 2, 0, 0, 0); tick();
        end
        nop();
        chk("sat_cnt", int'(sc1), 3);
        tick();

        // Asynchronous reset mid-stream with lw $8 in EX
        drive(1, 29, 0, 1, 0, 1, 8, 1, 0, 0); tick();
        drive(1, 8, 8, 1, 1, 1, 9, 0, 0, 0);
        chk("pre_reset_stall", int'(s0), 1);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_model();
        chk("mid_reset_stall", int'(s0), 0);
        chk("mid_reset_fwd", int'(fae0) + int'(fbe0) + int'(fai0) + int'(fbi0), 0);
        chk("mid_reset_cnt", int'(sc0) + int'(fc0), 0);
        tick();
        rst_n = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
